// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned W-bit binary to DIGITS packed BCD digits,
// one input bit per clock, MSB first; saturates to all nines when the value does not fit.
module bin_to_bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int N  = 4 * DIGITS;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   sr;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_adj;
  logic [N-1:0]   acc_shift;
  logic [N-1:0]   nines;
  logic [CW-1:0]  cnt;
  logic           sticky;
  logic           carry;
  logic           last;
  logic           ovf_final;

  assign busy      = (state == CONV);
  assign last      = (cnt == CW'(W - 1));
  assign carry     = acc_adj[N-1];
  assign acc_shift = {acc_adj[N-2:0], sr[W-1]};
  assign ovf_final = sticky | carry;

  // Per-digit add-3 correction; digits are independent, carries only travel via the shift.
  always_comb begin
    acc_adj = acc;
    nines   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nines[4*i +: 4] = 4'd9;
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr     <= bin;
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
          end
        end
        CONV: begin
          sr     <= sr << 1;
          acc    <= acc_shift;
          cnt    <= cnt + CW'(1);
          sticky <= ovf_final;
          // The final bit's carry-out must be folded in here, not from the registered sticky.
          if (last) begin
            done     <= 1'b1;
            overflow <= ovf_final;
            bcd      <= ovf_final ? nines : acc_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default 5-digit instance and a 4-digit saturating instance,
// checked against a decimal arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start5, start4;
  logic [15:0] bin5, bin4;
  logic        busy5, done5, ovf5;
  logic        busy4, done4, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W(16), .DIGITS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .bin(bin5),
    .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5)
  );

  bin_to_bcd_seq #(.W(16), .DIGITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digits by division, saturating to all nines when out of range.
  function automatic logic [31:0] ref_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      if (v >= pow10(d)) r = r | (32'd9 << (4 * i));
      else begin
        r = r | (32'(x % 10) << (4 * i));
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic int max_digit(input logic [31:0] b);
    int m = 0;
    for (int i = 0; i < 8; i++) begin
      if (int'((b >> (4 * i)) & 32'hF) > m) m = int'((b >> (4 * i)) & 32'hF);
    end
    return m;
  endfunction

  // One full conversion on the chosen instance (sel=0: 5 digits, sel=1: 4 digits).
  task automatic run_conv(input int sel, input int v, input string tag);
    int k, busy_cnt, d;
    logic [31:0] obs_bcd;
    logic        obs_ovf;
    d = (sel != 0) ? 4 : 5;
    @(negedge clk);
    if (sel != 0) begin start4 = 1'b1; bin4 = 16'(v); end
    else          begin start5 = 1'b1; bin5 = 16'(v); end
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start5 = 1'b0;
    k = 1;
    busy_cnt = 0;
    while (((sel != 0) ? done4 : done5) !== 1'b1 && k < 40) begin
      if (((sel != 0) ? busy4 : busy5) === 1'b1) busy_cnt++;
      @(negedge clk);
      k++;
    end
    obs_bcd = (sel != 0) ? {16'h0, bcd4} : {12'h0, bcd5};
    obs_ovf = (sel != 0) ? ovf4 : ovf5;
    check({tag, ".latency"}, 32'(k), 32'd17);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, ".bcd"}, obs_bcd, ref_bcd(v, d));
    check({tag, ".overflow"}, {31'h0, obs_ovf}, {31'h0, v >= pow10(d)});
    check({tag, ".digit_le9"}, {31'h0, max_digit(obs_bcd) <= 9}, 32'd1);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, {31'h0, (sel != 0) ? done4 : done5}, 32'd0);
    check({tag, ".bcd_hold"}, (sel != 0) ? {16'h0, bcd4} : {12'h0, bcd5}, ref_bcd(v, d));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, first_k, second_k, v;
    logic [31:0] got100;
    reset_n = 1'b0;
    start5 = 1'b0; start4 = 1'b0;
    bin5 = '0; bin4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy5", {31'h0, busy5}, 32'd0);
    check("reset.done5", {31'h0, done5}, 32'd0);
    check("reset.bcd5", {12'h0, bcd5}, 32'd0);
    check("reset.ovf5", {31'h0, ovf5}, 32'd0);
    check("reset.bcd4", {16'h0, bcd4}, 32'd0);
    reset_n = 1'b1;

    run_conv(0, 0, "zero");
    run_conv(0, 1234, "v1234");
    run_conv(0, 65535, "v65535");
    run_conv(0, 9, "v9");
    run_conv(0, 10, "v10");
    run_conv(0, 59999, "v59999");
    for (int i = 0; i < 250; i++) begin
      v = int'($urandom_range(0, 65535));
      run_conv(0, v, "rand5");
    end

    // Start held high: second conversion accepted on the done cycle, mid-CONV bin change ignored.
    @(negedge clk);
    start5 = 1'b1; bin5 = 16'd100;
    @(posedge clk);
    pulses = 0; first_k = -1; second_k = -1; got100 = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 3) bin5 = 16'd7;
      if (k == 18) start5 = 1'b0;
      if (done5 === 1'b1) begin
        pulses++;
        if (first_k < 0) begin first_k = k; got100 = {12'h0, bcd5}; end
        else if (second_k < 0) second_k = k;
        if (k == 34) check("held.second_bcd", {12'h0, bcd5}, 32'h00007);
      end
    end
    check("held.first_bcd", got100, 32'h00100);
    check("held.first_at", 32'(first_k), 32'd17);
    check("held.second_at", 32'(second_k), 32'd34);
    check("held.pulses", 32'(pulses), 32'd2);

    // 4-digit instance: saturation boundaries.
    run_conv(1, 12345, "d4_12345");
    check("d4_12345.nines", {16'h0, bcd4}, 32'h9999);
    run_conv(1, 9999, "d4_9999");
    run_conv(1, 10000, "d4_10000");
    run_conv(1, 0, "d4_zero");
    for (int i = 0; i < 80; i++) begin
      v = int'($urandom_range(0, 65535));
      run_conv(1, v, "rand4");
    end

    // Reset in the middle of a conversion.
    run_conv(0, 42, "pre_reset");
    @(negedge clk);
    start5 = 1'b1; bin5 = 16'd500;
    @(posedge clk);
    @(negedge clk);
    start5 = 1'b0;
    repeat (6) @(negedge clk);
    check("midreset.busy_before", {31'h0, busy5}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset.busy", {31'h0, busy5}, 32'd0);
    check("midreset.done", {31'h0, done5}, 32'd0);
    check("midreset.bcd", {12'h0, bcd5}, 32'd0);
    check("midreset.ovf", {31'h0, ovf5}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done5 === 1'b1) pulses++;
    end
    check("midreset.no_done", 32'(pulses), 32'd0);
    check("midreset.bcd_hold", {12'h0, bcd5}, 32'd0);
    run_conv(0, 7, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
